// File: rtl/systolic_mm_controller.sv
// systolic_mm_controller: buffers A/B and feeds skewed rows/columns into an NxN systolic MAC array.
// Optional SYSTOLIC_ABORT_EN adds an abort input that cancels a job in CLEAR or FEED.
module systolic_mm_controller #(
  parameter int WIDTH = 4,
  parameter int N     = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               load_a_we,
  input  logic               load_b_we,
  input  logic [3:0]         load_addr,
  input  logic [WIDTH-1:0]   load_data,
`ifdef SYSTOLIC_ABORT_EN
  input  logic               abort,
`endif
  output logic [N*WIDTH-1:0] a_row_out,
  output logic [N*WIDTH-1:0] b_col_out,
  output logic               pe_clear,
  output logic               busy,
  output logic               done,
  output logic               result_valid
);
  localparam int CW = ($clog2(3*N-2) < 3) ? 3 : $clog2(3*N-2);
  localparam int AW = $clog2(N*N);
  localparam logic [CW-1:0] LAST = CW'(3*N-3);
  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt;
  logic r_valid, w_valid, w_abort, w_wr;
  logic [WIDTH-1:0] r_a [N*N];
  logic [WIDTH-1:0] r_b [N*N];
`ifdef SYSTOLIC_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif
  assign pe_clear     = r_state == CLEAR;
  assign busy         = r_state != IDLE;
  assign done         = r_state == DONE;
  assign result_valid = r_valid;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_valid <= w_valid;
    end
  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt;
    w_valid = r_valid;
    case (r_state)
      IDLE: if (start) begin
        w_next  = CLEAR;
        w_valid = 1'b0;
      end
      CLEAR: begin
        w_next = w_abort ? IDLE : FEED;
        w_cnt  = '0;
      end
      FEED: begin
        w_next  = w_abort ? IDLE : (r_cnt == LAST ? DONE : FEED);
        w_cnt   = (w_abort || r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        w_valid = !w_abort && r_cnt == LAST;
      end
      default: w_next = IDLE;
    endcase
  end
  // Buffers only change in IDLE so a running job always sees a stable snapshot
  assign w_wr = r_state == IDLE && int'(load_addr) < N*N;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      for (int k = 0; k < N*N; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
    end else if (w_wr) begin
      if (load_a_we) r_a[AW'(load_addr)] <= load_data;
      if (load_b_we) r_b[AW'(load_addr)] <= load_data;
    end
  // Lane i is delayed by i cycles; outside its N-cycle window it must drive 0
  for (genvar i = 0; i < N; i++) begin : g_feed
    logic [CW-1:0] w_k;
    logic w_on;
    assign w_k = r_cnt - CW'(i);
    assign w_on = r_state == FEED && r_cnt >= CW'(i) && w_k < CW'(N);
    assign a_row_out[i*WIDTH +: WIDTH] = w_on ? r_a[AW'(i*N) + AW'(w_k)] : '0;
    assign b_col_out[i*WIDTH +: WIDTH] = w_on ? r_b[AW'(w_k)*AW'(N) + AW'(i)] : '0;
  end
endmodule

// File: tb/tb_systolic_mm_controller.sv
// tb_systolic_mm_controller: directed tests of the controller driving a 3x3 MAC array model.
module tb_systolic_mm_controller;
  logic CLK = 1'b0, RST = 1'b1, start = 1'b0, load_a_we = 1'b0, load_b_we = 1'b0;
  logic [3:0] load_addr = '0, load_data = '0;
  logic abort = 1'b0;
  logic [11:0] a_row_out, b_col_out;
  logic pe_clear, busy, done, result_valid;
  int checks = 0, failures = 0;

  localparam logic [35:0] M_SEQ = 36'h987654321;
  localparam logic [35:0] M_ID  = 36'h100010001;
  localparam logic [35:0] M_MAX = 36'hFFFFFFFFF;
  localparam logic [83:0] F_SEQ_A = {12'h000, 12'h000, 12'h900, 12'h860, 12'h753, 12'h042, 12'h001};
  localparam logic [83:0] F_SEQ_B = {12'h000, 12'h000, 12'h900, 12'h680, 12'h357, 12'h024, 12'h001};
  localparam logic [83:0] F_ID    = {12'h000, 12'h000, 12'h100, 12'h000, 12'h010, 12'h000, 12'h001};
  localparam logic [83:0] F_MAX   = {12'h000, 12'h000, 12'hF00, 12'hFF0, 12'hFFF, 12'h0FF, 12'h00F};
  localparam logic [89:0] C_SEQ = {10'd9, 10'd8, 10'd7, 10'd6, 10'd5, 10'd4, 10'd3, 10'd2, 10'd1};
  localparam logic [89:0] C_MAX = {9{10'd675}};

  always #5 CLK = ~CLK;

  systolic_mm_controller #(.WIDTH(4), .N(3)) dut (
    .CLK(CLK), .RST(RST), .start(start), .load_a_we(load_a_we), .load_b_we(load_b_we),
    .load_addr(load_addr), .load_data(load_data),
`ifdef SYSTOLIC_ABORT_EN
    .abort(abort),
`endif
    .a_row_out(a_row_out), .b_col_out(b_col_out), .pe_clear(pe_clear),
    .busy(busy), .done(done), .result_valid(result_valid)
  );

  logic [3:0] ra [9], rb [9], pa [9], pb [9];
  int acc [9];
  for (genvar k = 0; k < 9; k++) begin : g_pe
    if (k % 3 == 0) begin : g_a
      assign pa[k] = a_row_out[(k/3)*4 +: 4];
    end else begin : g_a
      assign pa[k] = ra[k-1];
    end
    if (k < 3) begin : g_b
      assign pb[k] = b_col_out[k*4 +: 4];
    end else begin : g_b
      assign pb[k] = rb[k-3];
    end
  end
  always @(posedge CLK or posedge RST)
    for (int k = 0; k < 9; k++)
      if (RST || pe_clear) begin
        acc[k] <= 0;
        ra[k]  <= '0;
        rb[k]  <= '0;
      end else begin
        acc[k] <= acc[k] + int'(pa[k]) * int'(pb[k]);
        ra[k]  <= pa[k];
        rb[k]  <= pb[k];
      end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input bit wa, input bit wb, input logic [35:0] m, input int n);
    for (int k = 0; k < n; k++) begin
      load_a_we = wa;
      load_b_we = wb;
      load_addr = 4'(k);
      load_data = m[k*4 +: 4];
      tick();
    end
    load_a_we = 1'b0;
    load_b_we = 1'b0;
  endtask

  task automatic run_job(input string nm, input logic [83:0] ea, input logic [83:0] eb,
                         input logic [89:0] ec, input bit disturb);
    start = 1'b1;
    tick();
    start = 1'b0;
    load_a_we = 1'b0;
    load_b_we = 1'b0;
    checks++;
    if ({pe_clear, busy, done, result_valid} !== 4'b1100) begin
      failures++;
      $display("FAIL %s clear_cycle got clr/busy/done/rv=%b want 1100", nm, {pe_clear, busy, done, result_valid});
    end
    for (int c = 0; c < 7; c++) begin
      tick();
      checks++;
      if (a_row_out !== ea[c*12 +: 12] || b_col_out !== eb[c*12 +: 12]) begin
        failures++;
        $display("FAIL %s feed cnt=%0d got a=%h b=%h want a=%h b=%h", nm, c, a_row_out, b_col_out,
                 ea[c*12 +: 12], eb[c*12 +: 12]);
      end
      checks++;
      if ({pe_clear, busy, done} !== 3'b010) begin
        failures++;
        $display("FAIL %s feed_ctl cnt=%0d got clr/busy/done=%b want 010", nm, c, {pe_clear, busy, done});
      end
      if (disturb) begin
        load_a_we = (c == 3);
        start     = (c == 3);
        load_addr = 4'd0;
        load_data = 4'd5;
      end
    end
    tick();
    checks++;
    if ({busy, done, result_valid, a_row_out, b_col_out} !== {3'b111, 24'h0}) begin
      failures++;
      $display("FAIL %s done_cycle got busy/done/rv=%b a=%h b=%h want 111 0 0", nm,
               {busy, done, result_valid}, a_row_out, b_col_out);
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (acc[k] !== int'(ec[k*10 +: 10])) begin
        failures++;
        $display("FAIL %s result C[%0d][%0d] got %0d want %0d", nm, k/3, k%3, acc[k], ec[k*10 +: 10]);
      end
    end
    tick();
    checks++;
    if ({busy, done, result_valid} !== 3'b001) begin
      failures++;
      $display("FAIL %s after_done got busy/done/rv=%b want 001", nm, {busy, done, result_valid});
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    checks++;
    if ({pe_clear, busy, done, result_valid, a_row_out, b_col_out} !== 28'h0) begin
      failures++;
      $display("FAIL reset got clr/busy/done/rv=%b a=%h b=%h want all 0",
               {pe_clear, busy, done, result_valid}, a_row_out, b_col_out);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_identity();
    load(1'b1, 1'b0, M_SEQ, 9);
    load(1'b0, 1'b1, M_ID, 9);
    run_job("identity", F_SEQ_A, F_ID, C_SEQ, 1'b0);
    tick();
    tick();
    checks++;
    if ({busy, result_valid} !== 2'b01) begin
      failures++;
      $display("FAIL valid_hold got busy/rv=%b want 01", {busy, result_valid});
    end
  endtask

  task automatic test_max();
    load(1'b1, 1'b1, M_MAX, 9);
    run_job("max", F_MAX, F_MAX, C_MAX, 1'b0);
  endtask

  task automatic test_back_to_back();
    load(1'b1, 1'b0, M_SEQ, 9);
    load(1'b0, 1'b1, M_ID, 9);
    run_job("busy_write", F_SEQ_A, F_ID, C_SEQ, 1'b1);
    run_job("rerun", F_SEQ_A, F_ID, C_SEQ, 1'b0);
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    RST = 1'b1;
    #1;
    checks++;
    if ({busy, done, result_valid, pe_clear, a_row_out, b_col_out} !== 28'h0) begin
      failures++;
      $display("FAIL mid_reset got busy/done/rv/clr=%b a=%h b=%h want all 0",
               {busy, done, result_valid, pe_clear}, a_row_out, b_col_out);
    end
    tick();
    RST = 1'b0;
    tick();
    run_job("zeroed_bufs", 84'h0, 84'h0, 90'h0, 1'b0);
    load(1'b0, 1'b1, M_SEQ, 9);
    load(1'b1, 1'b0, M_ID, 8);
    load_a_we = 1'b1;
    load_addr = 4'd8;
    load_data = 4'd1;
    run_job("write_with_start", F_ID, F_SEQ_B, C_SEQ, 1'b0);
  endtask

`ifdef SYSTOLIC_ABORT_EN
  task automatic test_abort();
    load(1'b1, 1'b0, M_SEQ, 9);
    load(1'b0, 1'b1, M_ID, 9);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, done, result_valid, a_row_out, b_col_out} !== 27'h0) begin
      failures++;
      $display("FAIL abort got busy/done/rv=%b a=%h b=%h want all 0",
               {busy, done, result_valid}, a_row_out, b_col_out);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if ({busy, done} !== 2'b00) begin
        failures++;
        $display("FAIL abort_quiet cyc=%0d got busy/done=%b want 00", c, {busy, done});
      end
    end
    run_job("abort_rerun", F_SEQ_A, F_ID, C_SEQ, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_identity();
    test_max();
    test_back_to_back();
    test_mid_reset();
`ifdef SYSTOLIC_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
